// File: rtl/sram_i_reader.sv
// rtl/sram_i_reader.sv - read-side sweep controller for the input-activation SRAM
module sram_i_reader #(
    parameter int WORD_AMOUNT  = 3136,
    parameter int BIT_PER_WORD = 145,
    parameter int ADDR_W       = $clog2(WORD_AMOUNT)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [ADDR_W-1:0]       base_addr,
    input  logic [ADDR_W-1:0]       length,
    output logic                    busy,
    output logic                    done,
    output logic                    sram_we,
    output logic [ADDR_W-1:0]       sram_addr,
    output logic                    sram_final_flag,
    input  logic [BIT_PER_WORD-1:0] sram_dout,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [BIT_PER_WORD-1:0] out_data,
    output logic                    out_last
);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t state, state_next;

    // remaining counts words still to issue after the one currently presented
    logic [ADDR_W-1:0]       remaining;
    // tag1: address presented this cycle; tag2: its data is on sram_dout now
    logic                    tag1_v, tag1_last, tag2_v, tag2_last;

    logic [BIT_PER_WORD-1:0] fifo_data [3];
    logic                    fifo_last [3];
    logic [1:0]              rd_ptr, wr_ptr, count, count_next;

    logic                    push, pop, room;
    logic                    start_issue, read_issue, issue, issue_last;
    logic [ADDR_W-1:0]       start_addr, addr_inc;

    assign push = tag2_v;
    assign pop  = (count != 2'd0) && out_ready;

    // occupancy after this edge, used both to update the FIFO and to gate issue
    always_comb begin
        count_next = count;
        if (push && !pop)
            count_next = count + 2'd1;
        else if (!push && pop)
            count_next = count - 2'd1;
    end

    // a new issue lands in the FIFO two edges later; tag1 lands one edge later
    assign room        = ({1'b0, count_next} + {2'b0, tag1_v}) < 3'd3;
    assign start_issue = (state == IDLE) && start && (length != '0);
    assign read_issue  = (state == READ) && room && (remaining != '0);
    assign issue       = start_issue || read_issue;
    assign issue_last  = start_issue ? (length == ADDR_W'(1)) : (remaining == ADDR_W'(1));

    assign start_addr  = (base_addr >= ADDR_W'(WORD_AMOUNT)) ? '0 : base_addr;
    assign addr_inc    = (sram_addr == ADDR_W'(WORD_AMOUNT - 1)) ? '0 : sram_addr + ADDR_W'(1);

    // state register
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    // next-state: sweep issues addresses, then waits for the final word to leave
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    if (length == '0)
                        state_next = DONE;
                    else if (length == ADDR_W'(1))
                        state_next = DRAIN;
                    else
                        state_next = READ;
                end
            end
            READ:    if (read_issue && issue_last) state_next = DRAIN;
            DRAIN:   if (pop && fifo_last[rd_ptr]) state_next = DONE;
            default: state_next = IDLE;
        endcase
    end

    // state-decoded status outputs
    always_comb begin
        busy = (state == READ) || (state == DRAIN);
        done = (state == DONE);
    end

    // address generator, remaining-word counter and read-tag pipeline
    always_ff @(posedge clk) begin
        if (rst) begin
            sram_addr <= '0;
            remaining <= '0;
            tag1_v    <= 1'b0;
            tag1_last <= 1'b0;
            tag2_v    <= 1'b0;
            tag2_last <= 1'b0;
        end else begin
            tag2_v    <= tag1_v;
            tag2_last <= tag1_last;
            tag1_v    <= issue;
            tag1_last <= issue && issue_last;
            if (start_issue) begin
                sram_addr <= start_addr;
                remaining <= length - ADDR_W'(1);
            end else if (read_issue) begin
                sram_addr <= addr_inc;
                remaining <= remaining - ADDR_W'(1);
            end
        end
    end

    // 3-entry output FIFO; storage is cleared so out_data reads 0 after reset
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= 2'd0;
            wr_ptr <= 2'd0;
            count  <= 2'd0;
            for (int i = 0; i < 3; i++) begin
                fifo_data[i] <= '0;
                fifo_last[i] <= 1'b0;
            end
        end else begin
            if (push) begin
                fifo_data[wr_ptr] <= sram_dout;
                fifo_last[wr_ptr] <= tag2_last;
                wr_ptr            <= (wr_ptr == 2'd2) ? 2'd0 : wr_ptr + 2'd1;
            end
            if (pop)
                rd_ptr <= (rd_ptr == 2'd2) ? 2'd0 : rd_ptr + 2'd1;
            count <= count_next;
        end
    end

    assign sram_we         = 1'b0;
    assign sram_final_flag = tag1_last;
    assign out_valid       = (count != 2'd0);
    assign out_data        = fifo_data[rd_ptr];
    assign out_last        = (count != 2'd0) && fifo_last[rd_ptr];

endmodule

// File: tb/tb_sram_i_reader.sv
// tb/tb_sram_i_reader.sv - directed self-checking bench for sram_i_reader
module tb_sram_i_reader;

    logic         clk;
    logic         rst;
    logic         start;
    logic [11:0]  base_addr;
    logic [11:0]  length;
    logic         busy;
    logic         done;
    logic         sram_we;
    logic [11:0]  sram_addr;
    logic         sram_final_flag;
    logic [144:0] sram_dout;
    logic         out_valid;
    logic         out_ready;
    logic [144:0] out_data;
    logic         out_last;

    int checks = 0;
    int errors = 0;

    logic [144:0] got_q[$];
    logic         last_q[$];
    int           cyc_q[$];
    logic [11:0]  addr_q[$];
    logic         flag_q[$];
    int           unstable;

    sram_i_reader dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
        .busy(busy), .done(done), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_final_flag(sram_final_flag), .sram_dout(sram_dout),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [144:0] word_of(input int a);
        logic [144:0] w;
        w = 145'(a);
        return w | (w << 120);
    endfunction

    // registered-read SRAM: word appears one cycle after its address
    always @(posedge clk) sram_dout <= word_of(int'(sram_addr));

    function automatic bit bp_ready(input int c);
        if (c >= 6 && c <= 15) return 1'b0;
        return ((c * 5) % 7) < 4;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [11:0] b, input logic [11:0] l);
        tick();
        start     = 1'b1;
        base_addr = b;
        length    = l;
        tick();
        start     = 1'b0;
    endtask

    // gathers handshaked words from cycle 1 until done or the cycle budget runs out
    task automatic collect(input int max_cycles, input bit bp, input int re_cyc,
                           output bit got_done, output int done_cyc);
        logic [144:0] held;
        bit           stalled;
        got_q.delete(); last_q.delete(); cyc_q.delete(); addr_q.delete(); flag_q.delete();
        unstable = 0;
        stalled  = 1'b0;
        held     = '0;
        got_done = 1'b0;
        done_cyc = -1;
        for (int c = 1; c <= max_cycles && !got_done; c++) begin
            out_ready = bp ? bp_ready(c) : 1'b1;
            start     = (c == re_cyc);
            if (c == re_cyc) begin
                base_addr = 12'd50;
                length    = 12'd3;
            end
            addr_q.push_back(sram_addr);
            flag_q.push_back(sram_final_flag);
            if (stalled && out_data !== held) unstable++;
            if (out_valid && out_ready) begin
                got_q.push_back(out_data);
                last_q.push_back(out_last);
                cyc_q.push_back(c);
            end
            stalled = out_valid && !out_ready;
            held    = out_data;
            if (done) begin
                got_done = 1'b1;
                done_cyc = c;
            end else begin
                tick();
            end
        end
        start     = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({busy, done, out_valid, out_last, sram_final_flag, sram_we} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags got %b exp 000000", {busy, done, out_valid, out_last, sram_final_flag, sram_we});
        end
        checks++;
        if (sram_addr !== 12'd0 || out_data !== '0) begin
            errors++;
            $display("FAIL reset_addr_data got addr %0d data %h exp 0", sram_addr, out_data);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        bit gd;
        int dc;
        pulse_start(12'd0, 12'd8);
        checks++;
        if (busy !== 1'b1 || sram_addr !== 12'd0) begin
            errors++;
            $display("FAIL basic_cycle1 got busy %b addr %0d exp busy 1 addr 0", busy, sram_addr);
        end
        collect(100, 1'b0, -1, gd, dc);
        checks++;
        if (got_q.size() != 8) begin
            errors++;
            $display("FAIL basic_count got %0d exp 8", got_q.size());
        end
        for (int i = 0; i < 8 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== word_of(i) || last_q[i] !== (i == 7) || cyc_q[i] != i + 3) begin
                errors++;
                $display("FAIL basic_word[%0d] got %h last %b cyc %0d exp %h last %b cyc %0d",
                         i, got_q[i], last_q[i], cyc_q[i], word_of(i), (i == 7), i + 3);
            end
        end
        checks++;
        if (!gd || dc != 11) begin
            errors++;
            $display("FAIL basic_done got done %b cycle %0d exp cycle 11", gd, dc);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_busy_at_done got %b exp 0", busy);
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_done_pulse got done %b busy %b exp 0 0", done, busy);
        end
    endtask

    task automatic test_wrap();
        bit gd;
        int dc;
        int exp_a[4] = '{3134, 3135, 0, 1};
        pulse_start(12'd3134, 12'd4);
        collect(100, 1'b0, -1, gd, dc);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (addr_q[k] !== 12'(exp_a[k]) || flag_q[k] !== (k == 3)) begin
                errors++;
                $display("FAIL wrap_addr[%0d] got %0d flag %b exp %0d flag %b",
                         k, addr_q[k], flag_q[k], exp_a[k], (k == 3));
            end
        end
        checks++;
        if (got_q.size() != 4 || !gd || dc != 7) begin
            errors++;
            $display("FAIL wrap_count got %0d done %b cyc %0d exp 4 1 7", got_q.size(), gd, dc);
        end
        for (int k = 0; k < 4 && k < got_q.size(); k++) begin
            checks++;
            if (got_q[k] !== word_of(exp_a[k])) begin
                errors++;
                $display("FAIL wrap_data[%0d] got %h exp %h", k, got_q[k], word_of(exp_a[k]));
            end
        end
    endtask

    task automatic test_backpressure();
        bit gd;
        int dc;
        pulse_start(12'd100, 12'd16);
        collect(300, 1'b1, -1, gd, dc);
        checks++;
        if (got_q.size() != 16 || !gd) begin
            errors++;
            $display("FAIL bp_count got %0d done %b exp 16 1", got_q.size(), gd);
        end
        for (int k = 0; k < 16 && k < got_q.size(); k++) begin
            checks++;
            if (got_q[k] !== word_of(100 + k) || last_q[k] !== (k == 15)) begin
                errors++;
                $display("FAIL bp_word[%0d] got %h last %b exp %h last %b",
                         k, got_q[k], last_q[k], word_of(100 + k), (k == 15));
            end
        end
        checks++;
        if (unstable != 0) begin
            errors++;
            $display("FAIL bp_hold got %0d changes exp 0", unstable);
        end
    endtask

    task automatic test_length0();
        pulse_start(12'd7, 12'd0);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL len0_cycle1 got done %b busy %b valid %b exp 1 0 0", done, busy, out_valid);
        end
        tick();
        checks++;
        if (done !== 1'b0 || out_valid !== 1'b0 || sram_final_flag !== 1'b0) begin
            errors++;
            $display("FAIL len0_cycle2 got done %b valid %b flag %b exp 0 0 0", done, out_valid, sram_final_flag);
        end
    endtask

    task automatic test_back_to_back_start();
        bit gd;
        int dc;
        pulse_start(12'd10, 12'd5);
        collect(100, 1'b0, 2, gd, dc);
        checks++;
        if (got_q.size() != 5 || !gd) begin
            errors++;
            $display("FAIL restart_count got %0d done %b exp 5 1", got_q.size(), gd);
        end
        for (int k = 0; k < 5 && k < got_q.size(); k++) begin
            checks++;
            if (got_q[k] !== word_of(10 + k)) begin
                errors++;
                $display("FAIL restart_word[%0d] got %h exp %h", k, got_q[k], word_of(10 + k));
            end
        end
    endtask

    task automatic test_base_oob();
        bit gd;
        int dc;
        pulse_start(12'd4000, 12'd2);
        checks++;
        if (sram_addr !== 12'd0) begin
            errors++;
            $display("FAIL oob_addr got %0d exp 0", sram_addr);
        end
        collect(100, 1'b0, -1, gd, dc);
        checks++;
        if (got_q.size() != 2 || !gd || got_q[0] !== word_of(0) || got_q[1] !== word_of(1)) begin
            errors++;
            $display("FAIL oob_words got %0d words done %b exp words 0,1", got_q.size(), gd);
        end
    endtask

    task automatic test_reset_mid();
        bit gd;
        int dc;
        int stray;
        out_ready = 1'b0;
        pulse_start(12'd200, 12'd10);
        tick();
        tick();
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== word_of(200) || busy !== 1'b1) begin
            errors++;
            $display("FAIL rmid_pre got valid %b busy %b data %h exp 1 1 %h", out_valid, busy, out_data, word_of(200));
        end
        rst = 1'b1;
        tick();
        checks++;
        if ({busy, done, out_valid, out_last, sram_final_flag, sram_we} !== 6'b0 ||
            sram_addr !== 12'd0 || out_data !== '0) begin
            errors++;
            $display("FAIL rmid_outputs got flags %b addr %0d data %h exp all 0",
                     {busy, done, out_valid, out_last, sram_final_flag, sram_we}, sram_addr, out_data);
        end
        rst       = 1'b0;
        out_ready = 1'b1;
        stray     = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (out_valid || busy) stray++;
        end
        checks++;
        if (stray != 0) begin
            errors++;
            $display("FAIL rmid_idle got %0d active cycles exp 0", stray);
        end
        pulse_start(12'd5, 12'd2);
        collect(100, 1'b0, -1, gd, dc);
        checks++;
        if (got_q.size() != 2 || !gd || got_q[0] !== word_of(5) || got_q[1] !== word_of(6)) begin
            errors++;
            $display("FAIL rmid_fresh got %0d words done %b exp words 5,6", got_q.size(), gd);
        end
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        length    = '0;
        out_ready = 1'b1;
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_length0();
        test_back_to_back_start();
        test_base_oob();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
